// File: rtl/ripple_carry_adder.sv
// ripple_carry_adder: registered unsigned adder built from a visible chain of one-bit full adders.
// Sum[WIDTH] is the carry-out; reset clears the output register asynchronously.
module ripple_carry_adder_fa (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    logic w_p;
    assign w_p = i_a ^ i_b;
    assign o_s = w_p ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & w_p);
endmodule

module ripple_carry_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH:0]   Sum
);
    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_s;
    assign w_c[0] = 1'b0;
    // Explicit stage chain so synthesis keeps the ripple structure instead of inferring an adder.
    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        ripple_carry_adder_fa u_fa (
            .i_a(A[i]),
            .i_b(B[i]),
            .i_c(w_c[i]),
            .o_s(w_s[i]),
            .o_c(w_c[i+1])
        );
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) Sum <= '0;
        else Sum <= {w_c[WIDTH], w_s};
    end
endmodule

// File: tb/tb_ripple_carry_adder.sv
// tb_ripple_carry_adder: scoreboard bench for WIDTH=1, 4 and 8 instances of ripple_carry_adder.
module tb_ripple_carry_adder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [0:0] A1 = '0, B1 = '0;
    logic [1:0] Sum1;
    logic [3:0] A4 = '0, B4 = '0;
    logic [4:0] Sum4;
    logic [7:0] A8 = '0, B8 = '0;
    logic [8:0] Sum8;
    logic [8:0] q1[$], q4[$], q8[$];
    int total = 0, bad = 0;

    ripple_carry_adder #(.WIDTH(1)) u_w1 (.clk(clk), .rst_n(rst_n), .A(A1), .B(B1), .Sum(Sum1));
    ripple_carry_adder #(.WIDTH(4)) u_w4 (.clk(clk), .rst_n(rst_n), .A(A4), .B(B4), .Sum(Sum4));
    ripple_carry_adder #(.WIDTH(8)) u_w8 (.clk(clk), .rst_n(rst_n), .A(A8), .B(B8), .Sum(Sum8));

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [8:0] act, input logic [8:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", n, act, exp);
        end
    endtask

    // Operands go out on the falling edge; the expected sum is queued for the next rising edge.
    task automatic apply(input int w, input logic [7:0] a, input logic [7:0] b, input logic [8:0] e);
        @(negedge clk);
        if (w == 1) begin A1 = a[0]; B1 = b[0]; q1.push_back(e); end
        else if (w == 4) begin A4 = a[3:0]; B4 = b[3:0]; q4.push_back(e); end
        else begin A8 = a; B8 = b; q8.push_back(e); end
    endtask

    always @(posedge clk) begin
        #1;
        if (q1.size() > 0) chk("sum_w1", {7'b0, Sum1}, q1.pop_front());
        if (q4.size() > 0) chk("sum_w4", {4'b0, Sum4}, q4.pop_front());
        if (q8.size() > 0) chk("sum_w8", Sum8, q8.pop_front());
    end

    logic [3:0] da[11] = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3, 4'd4, 4'd9, 4'd15, 4'd15};
    logic [3:0] db[11] = '{4'd0, 4'd0, 4'd9, 4'd1, 4'd2, 4'd2, 4'd3, 4'd12, 4'd12, 4'd8, 4'd15};
    logic [4:0] de[11] = '{5'b00000, 5'b00001, 5'b01010, 5'b00011, 5'b00100, 5'b00101,
                           5'b00110, 5'b10000, 5'b10101, 5'b10111, 5'b11110};

    initial begin
        A4 = 4'hF; B4 = 4'hF; A1 = 1'b1; B1 = 1'b1; A8 = 8'hFF; B8 = 8'hFF;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_w4", {4'b0, Sum4}, 9'd0);
        chk("rst_async_w1", {7'b0, Sum1}, 9'd0);
        chk("rst_async_w8", Sum8, 9'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_hold_w4", {4'b0, Sum4}, 9'd0);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 11; i++) apply(4, {4'b0, da[i]}, {4'b0, db[i]}, {4'b0, de[i]});
        // Hold: operands change mid-cycle, Sum must keep 3+4 until the next edge.
        apply(4, 8'd3, 8'd4, 9'd7);
        @(negedge clk);
        A4 = 4'd1; B4 = 4'd1;
        #2;
        A4 = 4'd9; B4 = 4'd6;
        q4.push_back(9'd15);
        #1;
        chk("hold_w4", {4'b0, Sum4}, 9'd7);
        // Reset mid-stream clears a 15+15 result; first edge after release loads 5+6.
        apply(4, 8'd15, 8'd15, 9'd30);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_async_w4", {4'b0, Sum4}, 9'd0);
        @(posedge clk);
        #1;
        chk("midrst_hold_w4", {4'b0, Sum4}, 9'd0);
        #1;
        rst_n = 1'b1;
        apply(4, 8'd5, 8'd6, 9'd11);
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++) apply(4, 8'(a), 8'(b), 9'(a + b));
        for (int a = 0; a < 2; a++)
            for (int b = 0; b < 2; b++) apply(1, 8'(a), 8'(b), 9'(a + b));
        apply(8, 8'd255, 8'd255, 9'd510);
        apply(8, 8'd0, 8'd0, 9'd0);
        apply(8, 8'd1, 8'd255, 9'd256);
        for (int i = 0; i < 200; i++) begin
            int a, b;
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 255));
            apply(8, 8'(a), 8'(b), 9'(a + b));
        end
        repeat (3) @(posedge clk);
        #2;
        chk("drain", 9'(q1.size() + q4.size() + q8.size()), 9'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
